prog_counter: RTL and testbench
===============================

# prog_counter

10-bit program counter register for the RAT MCU fetch path, sitting directly downstream of the PC input multiplexer and feeding the instruction ROM address. It captures the multiplexer output `DIN` on load, self-increments on fetch, and drives `PC_COUNT`. It also tracks interrupt-service state: it recognises a load of the interrupt vector, records the interrupted return address, and flags illegal nesting. An optional wrap detector flags increments past the top of program memory.

## Interface
Parameters:
- `WIDTH`, 10, PC and address width; must match the multiplexer output width.
- `INT_VEC`, 10'h3FF, interrupt vector address; a load of this value enters ISR state.

Ports:
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RST`  in  1  reset; one clock, synchronous, active-high.
- `DIN`  in  WIDTH  next-PC value from the PC multiplexer.
- `PC_LD`  in  1  load `DIN` into PC this cycle.
- `PC_INC`  in  1  increment PC this cycle.
- `RETI`  in  1  return-from-interrupt strobe from control unit; leaves ISR state.
- `PC_COUNT`  out  WIDTH  current PC; ROM address.
- `IN_ISR`  out  1  high while executing the interrupt handler.
- `RET_ADDR`  out  WIDTH  PC value at the moment the vector was loaded.
- `NEST_ERR`  out  1  sticky; vector load seen while already `IN_ISR`.
- `WRAP_ERR`  out  1  sticky; present only with `PC_WRAP_DET_EN`.

## Operation
- PC update priority: `RST` > `PC_LD` > `PC_INC` > hold.
- `PC_LD`: PC <= `DIN`. `PC_INC`: PC <= PC + 1, modulo 2^WIDTH (0x3FF -> 0x000). Both high: load wins, no increment.
- ISR tracker states: NORMAL, ISR.
  - NORMAL -> ISR: `PC_LD` high and `DIN == INT_VEC`; `RET_ADDR` <= current `PC_COUNT` (pre-load value) same edge.
  - ISR -> NORMAL: `RETI` high. `RET_ADDR` retains its value.
  - ISR, vector load again: stay ISR, `RET_ADDR` NOT overwritten, `NEST_ERR` <= 1.
  - `RETI` in NORMAL: ignored, no state or output change.
  - `RETI` and vector load same cycle in ISR: `RETI` wins -> NORMAL; no nest error. Same cycle in NORMAL: vector load wins -> ISR.
  - `RETI` concurrent with an ordinary `PC_LD` (return target from scratch stack): both take effect.
- `IN_ISR` = (state == ISR), registered.
- Sticky flags clear only on `RST`.

## Timing
- Reset values: `PC_COUNT` 0x000, `IN_ISR` 0, `RET_ADDR` 0x000, `NEST_ERR` 0, `WRAP_ERR` 0; state NORMAL.
- `RST` mid-ISR or concurrent with `PC_LD`/`PC_INC`/`RETI`: reset wins, all outputs to reset values next edge.
- Latency: all outputs change one edge after the controlling input is sampled; no combinational path from inputs to outputs.
- `DIN` must be stable at the edge where `PC_LD` is sampled; no handshake, control unit asserts strobes for exactly the cycles required.

## Configuration
- `PC_WRAP_DET_EN` defined: `WRAP_ERR` port exists; set sticky when `PC_INC` applied (not overridden by `PC_LD`) with PC == 2^WIDTH-1. PC still wraps to 0.
- Not defined: `WRAP_ERR` port and its logic absent; wrap is silent.

## Structure
- Shared package `rat_pkg`: `PC_WIDTH` (10), `INT_VECTOR` (10'h3FF), enum `isr_state_t` {NORMAL, ISR}; parameter defaults taken from it.
- One sub-module natural: `pc_isr_tracker` (state, `RET_ADDR`, `NEST_ERR`), instantiated by `prog_counter`; PC register and wrap detector stay in the top.

## Test plan
- Reset then 3x `PC_INC` -> `PC_COUNT` 0x000, 0x001, 0x002, 0x003; all flags 0.
- PC=0x040, `PC_LD`=1, `PC_INC`=1, `DIN`=0x123 -> `PC_COUNT`=0x123 next edge (not 0x124).
- PC=0x055, `PC_LD` with `DIN`=0x3FF -> `PC_COUNT`=0x3FF, `IN_ISR`=1, `RET_ADDR`=0x055; then `RETI`+`PC_LD` `DIN`=0x055 -> `IN_ISR`=0, `PC_COUNT`=0x055.
- In ISR, second vector load from PC=0x3FF -> `NEST_ERR`=1, `RET_ADDR` unchanged 0x055; `RETI` in NORMAL -> no change.
- With `PC_WRAP_DET_EN`: PC=0x3FF, `PC_INC` -> `PC_COUNT`=0x000, `WRAP_ERR`=1, stays 1 until `RST`.
- In ISR with `NEST_ERR`=1, assert `RST` with `PC_INC` -> all outputs reset values next edge.

Source files
------------

// File: rtl/rat_pkg.sv
// rat_pkg: shared RAT MCU constants and the ISR tracker state type.
package rat_pkg;
  localparam int PC_WIDTH = 10;
  localparam logic [PC_WIDTH-1:0] INT_VECTOR = 10'h3FF;
  typedef enum logic [0:0] {NORMAL = 1'b0, ISR = 1'b1} isr_state_t;
endpackage

// File: rtl/pc_isr_tracker.sv
// pc_isr_tracker: interrupt-service state, return address capture and sticky nest error.
module pc_isr_tracker
  import rat_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_vec_ld,
  input  logic             i_reti,
  input  logic [WIDTH-1:0] i_pc,
  output logic             o_in_isr,
  output logic [WIDTH-1:0] o_ret_addr,
  output logic             o_nest_err
);
  isr_state_t       r_state;
  logic [WIDTH-1:0] r_ret;
  logic             r_nest;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= NORMAL;
      r_ret   <= '0;
      r_nest  <= 1'b0;
    end else if (r_state == ISR) begin
      // RETI takes precedence so a return that reloads the vector is not a nest
      if (i_reti) r_state <= NORMAL;
      else if (i_vec_ld) r_nest <= 1'b1;
    end else if (i_vec_ld) begin
      r_state <= ISR;
      r_ret   <= i_pc;
    end
  end
  assign o_in_isr   = (r_state == ISR);
  assign o_ret_addr = r_ret;
  assign o_nest_err = r_nest;
endmodule

// File: rtl/prog_counter.sv
// prog_counter: RAT MCU program counter with ISR tracking.
// Optional wrap detector and WRAP_ERR port enabled by defining PC_WRAP_DET_EN.
module prog_counter
  import rat_pkg::*;
#(
  parameter int               WIDTH   = PC_WIDTH,
  parameter logic [WIDTH-1:0] INT_VEC = INT_VECTOR
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             PC_LD,
  input  logic             PC_INC,
  input  logic             RETI,
  output logic [WIDTH-1:0] PC_COUNT,
  output logic             IN_ISR,
  output logic [WIDTH-1:0] RET_ADDR,
  output logic             NEST_ERR
`ifdef PC_WRAP_DET_EN
  ,
  output logic             WRAP_ERR
`endif
);
  logic [WIDTH-1:0] r_pc;
  logic             w_vec_ld;
  assign w_vec_ld = PC_LD && (DIN == INT_VEC);
  always_ff @(posedge CLK) begin
    if (RST) r_pc <= '0;
    else if (PC_LD) r_pc <= DIN;
    else if (PC_INC) r_pc <= r_pc + WIDTH'(1);
  end
  assign PC_COUNT = r_pc;
`ifdef PC_WRAP_DET_EN
  logic r_wrap;
  always_ff @(posedge CLK) begin
    if (RST) r_wrap <= 1'b0;
    else if (PC_INC && !PC_LD && (r_pc == '1)) r_wrap <= 1'b1;
  end
  assign WRAP_ERR = r_wrap;
`endif
  pc_isr_tracker #(.WIDTH(WIDTH)) u_isr (
    .CLK        (CLK),
    .RST        (RST),
    .i_vec_ld   (w_vec_ld),
    .i_reti     (RETI),
    .i_pc       (r_pc),
    .o_in_isr   (IN_ISR),
    .o_ret_addr (RET_ADDR),
    .o_nest_err (NEST_ERR)
  );
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed and random scoreboard checks of prog_counter.
module tb_prog_counter;
  typedef struct {
    logic [9:0] pc;
    logic       isr;
    logic [9:0] ret;
    logic       nest;
    logic       wrap;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0, ld = 1'b0, inc = 1'b0, reti = 1'b0;
  logic [9:0] din = '0;
  logic [9:0] pc_count, ret_addr;
  logic       in_isr, nest_err, wrap_err;
  int         n_vec = 0, n_err = 0;
  exp_t       q[$];
  logic [9:0] m_pc = '0, m_ret = '0;
  logic       m_isr = 1'b0, m_nest = 1'b0, m_wrap = 1'b0;
  always #5 clk = ~clk;
  prog_counter dut (
    .CLK      (clk),
    .RST      (rst),
    .DIN      (din),
    .PC_LD    (ld),
    .PC_INC   (inc),
    .RETI     (reti),
    .PC_COUNT (pc_count),
    .IN_ISR   (in_isr),
    .RET_ADDR (ret_addr),
    .NEST_ERR (nest_err)
`ifdef PC_WRAP_DET_EN
    ,
    .WRAP_ERR (wrap_err)
`endif
  );
`ifndef PC_WRAP_DET_EN
  assign wrap_err = 1'b0;
`endif
  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // Reference model advances on stimulus; expectation is queued until the edge is taken.
  task automatic step(input logic s_rst, input logic s_ld, input logic s_inc, input logic s_reti, input logic [9:0] s_din);
    exp_t e;
    logic vec;
    rst = s_rst; ld = s_ld; inc = s_inc; reti = s_reti; din = s_din;
    vec = s_ld && (s_din == 10'h3FF);
    if (s_rst) begin
      m_pc = '0; m_ret = '0; m_isr = 1'b0; m_nest = 1'b0; m_wrap = 1'b0;
    end else begin
      if (s_inc && !s_ld && m_pc == 10'h3FF) m_wrap = 1'b1;
      if (m_isr) begin
        if (s_reti) m_isr = 1'b0;
        else if (vec) m_nest = 1'b1;
      end else if (vec) begin
        m_isr = 1'b1;
        m_ret = m_pc;
      end
      m_pc = s_ld ? s_din : s_inc ? m_pc + 10'd1 : m_pc;
    end
    e.pc = m_pc; e.isr = m_isr; e.ret = m_ret; e.nest = m_nest; e.wrap = m_wrap;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("pc", pc_count, e.pc);
    check("in_isr", {9'd0, in_isr}, {9'd0, e.isr});
    check("ret_addr", ret_addr, e.ret);
    check("nest_err", {9'd0, nest_err}, {9'd0, e.nest});
`ifdef PC_WRAP_DET_EN
    check("wrap_err", {9'd0, wrap_err}, {9'd0, e.wrap});
`endif
  endtask
  initial begin
    step(1, 0, 0, 0, 10'h000);
    check("reset_pc", pc_count, 10'h000);
    step(0, 0, 1, 0, 10'h000);
    step(0, 0, 1, 0, 10'h000);
    step(0, 0, 1, 0, 10'h000);
    check("inc3_pc", pc_count, 10'h003);
    step(0, 1, 0, 0, 10'h040);
    step(0, 1, 1, 0, 10'h123);
    check("ld_beats_inc", pc_count, 10'h123);
    step(0, 0, 0, 0, 10'h2AA);
    step(0, 1, 0, 0, 10'h055);
    step(0, 1, 0, 0, 10'h3FF);
    check("isr_ret", ret_addr, 10'h055);
    check("isr_in", {9'd0, in_isr}, 10'h001);
    step(0, 1, 0, 1, 10'h3FF);
    check("reti_vec_isr", {9'd0, in_isr}, 10'h000);
    check("reti_vec_nonest", {9'd0, nest_err}, 10'h000);
    step(0, 1, 0, 1, 10'h3FF);
    check("reti_vec_normal", {9'd0, in_isr}, 10'h001);
    step(0, 1, 0, 1, 10'h055);
    step(0, 1, 0, 0, 10'h3FF);
    step(0, 1, 0, 0, 10'h3FF);
    check("nest_set", {9'd0, nest_err}, 10'h001);
    check("nest_ret_kept", ret_addr, 10'h055);
    step(0, 1, 0, 1, 10'h055);
    check("reti_ld_pc", pc_count, 10'h055);
    step(0, 0, 0, 1, 10'h000);
    check("reti_normal_pc", pc_count, 10'h055);
    step(0, 1, 0, 0, 10'h3FE);
    step(0, 0, 1, 0, 10'h000);
    step(0, 0, 1, 0, 10'h000);
    check("wrap_pc", pc_count, 10'h000);
`ifdef PC_WRAP_DET_EN
    check("wrap_flag", {9'd0, wrap_err}, 10'h001);
    step(0, 0, 1, 0, 10'h000);
    check("wrap_sticky", {9'd0, wrap_err}, 10'h001);
`endif
    step(0, 1, 0, 0, 10'h3FF);
    step(0, 1, 0, 0, 10'h3FF);
    step(1, 0, 1, 1, 10'h3FF);
    check("rst_pc", pc_count, 10'h000);
    check("rst_nest", {9'd0, nest_err}, 10'h000);
    check("rst_isr", {9'd0, in_isr}, 10'h000);
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0 ? 10'h3FF : 10'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
